// File: rtl/score_display_ctrl.sv
// score_display_ctrl: BCD score/best keeper and three-digit HEX display sequencer.
// Ports: clk, reset (sync, active-high); start/point/gameover event inputs;
// hex0..hex2 active-low {g,f,e,d,c,b,a} digits; score/best binary; phase = FSM state.
module score_display_ctrl #(
  parameter int unsigned SHOW_CYCLES = 25_000_000,
  parameter int unsigned MAX_SCORE   = 999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       point,
  input  logic       gameover,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [9:0] score,
  output logic [9:0] best,
  output logic [1:0] phase
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, SHOW_SCORE = 2'b10, SHOW_BEST = 2'b11} state_t;
  localparam logic [6:0] DASH = 7'b0111111;
  state_t state;
  logic [3:0] s0, s1, s2, b0, b1, b2, i0, i1, i2, n0, n1, n2;
  logic [31:0] timer;
  logic [9:0] nbin;
  logic sel_best;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = DASH;
    endcase
  endfunction
  function automatic logic [9:0] bin(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bin = 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(o);
  endfunction
  // ripple-carry BCD increment, then gated by point and saturation
  always_comb begin
    i0 = s0 == 4'd9 ? 4'd0 : s0 + 4'd1;
    i1 = s0 != 4'd9 ? s1 : (s1 == 4'd9 ? 4'd0 : s1 + 4'd1);
    i2 = (s0 == 4'd9 && s1 == 4'd9) ? s2 + 4'd1 : s2;
    {n2, n1, n0} = (point && score < 10'(MAX_SCORE)) ? {i2, i1, i0} : {s2, s1, s0};
    nbin = bin(n2, n1, n0);
    sel_best = state == SHOW_BEST;
  end
  assign phase = state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {s2, s1, s0} <= '0;
      {b2, b1, b0} <= '0;
      timer <= '0;
      score <= '0;
      best <= '0;
      {hex2, hex1, hex0} <= {DASH, DASH, DASH};
    end else begin
      hex0 <= state == IDLE ? DASH : seg(sel_best ? b0 : s0);
      hex1 <= state == IDLE ? DASH : seg(sel_best ? b1 : s1);
      hex2 <= state == IDLE ? DASH : seg(sel_best ? b2 : s2);
      case (state)
        IDLE: if (start) begin
          state <= PLAY;
          {s2, s1, s0} <= '0;
          score <= '0;
        end
        PLAY: begin
          {s2, s1, s0} <= {n2, n1, n0};
          score <= nbin;
          if (gameover) begin
            state <= SHOW_SCORE;
            timer <= SHOW_CYCLES - 1;
            if (nbin > best) begin
              {b2, b1, b0} <= {n2, n1, n0};
              best <= nbin;
            end
          end
        end
        default: if (start) begin
          state <= PLAY;
          {s2, s1, s0} <= '0;
          score <= '0;
          timer <= '0;
        end else if (timer == '0) begin
          state <= state == SHOW_SCORE ? SHOW_BEST : SHOW_SCORE;
          timer <= SHOW_CYCLES - 1;
        end else begin
          timer <= timer - 32'd1;
        end
      endcase
    end
  end
endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
Sequences the three-digit seven-segment score display for the Flappy Bird game. Keeps the live score and best score as BCD counters, so no divide/modulo hardware is needed. Arbitrates which value drives HEX0–HEX2 according to game phase: dashes when idle, live score during play, and after game-over it alternates between final score and best score. Sits between game-logic event pulses and the board HEX pins.

Parameters:
SHOW_CYCLES, 25_000_000, clock cycles each value is shown in the game-over alternation (0.5 s at 50 MHz); legal range 2..2^32-1
MAX_SCORE, 999, saturation value of the score counter; must be ≤999

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin a new game
point  in  1  one-cycle pulse: bird passed a pipe
gameover  in  1  level or pulse: bird collided
hex0  out  7  ones digit, active-low segments {g,f,e,d,c,b,a}
hex1  out  7  tens digit, same encoding
hex2  out  7  hundreds digit, same encoding
score  out  10  live score in binary (0..MAX_SCORE)
best  out  10  best score in binary
phase  out  2  current FSM state encoding (00 IDLE, 01 PLAY, 10 SHOW_SCORE, 11 SHOW_BEST)

Behaviour:
- Reset (synchronous, highest priority): state=IDLE; score BCD=000; best BCD=000; timer=0; hex0..2=7'b0111111 (dash); score=0; best=0.
- Digit encoding (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any non-BCD digit value displays as dash.
- Score counter: three 4-bit BCD digits with ripple carry.
  - A point in PLAY increments it at the sampling edge.
  - Saturates at MAX_SCORE: a point at MAX_SCORE leaves it unchanged.
  - Binary `score` = d2*100 + d1*10 + d0, registered alongside the BCD digits.
- hex outputs are registered from the currently selected BCD source. A change in the source is visible on hex at the following edge (1-cycle latency after the counter updates).
- FSM:
  - IDLE: hex shows dashes. start → PLAY and clear score to 000. point and gameover are ignored.
  - PLAY: hex shows the live score.
    - point increments the score.
    - gameover → SHOW_SCORE. On the same edge, if the final score (including any simultaneous point) > best, load best from it. Timer loads SHOW_CYCLES-1.
    - start is ignored.
  - SHOW_SCORE: hex shows the final score. Timer decrements each cycle. At timer==0 → SHOW_BEST and reload the timer.
  - SHOW_BEST: hex shows best. At timer==0 → SHOW_SCORE and reload the timer.
  - In SHOW_SCORE or SHOW_BEST, start → PLAY, clear score, keep best, timer=0. start has priority over timer expiry. point and gameover are ignored.
- Simultaneous point+gameover in PLAY: the point is counted first, and the final and best comparison use the incremented value.
- Simultaneous start+gameover in IDLE: start is taken, gameover is ignored.
- gameover held high in PLAY: the transition fires once. Staying high has no effect outside PLAY.
- Best comparison is on the 10-bit binary values. An equal score does not rewrite best.
- Reset mid-game clears both score and best.

Test Plan:
- Reset, then idle 10 cycles → hex0..2=0111111, phase=00, score=0, best=0.
- start, then 12 point pulses spaced 3 cycles → score=12, 2 cycles after the last point hex0=0100100, hex1=1111001, hex2=1000000.
- SHOW_CYCLES=4, score=12, gameover → phase=10 showing 012, after 4 cycles phase=11 showing best=012, after 4 more back to 10; start → phase=01, score=0, best=12.
- Second game with 5 points, then gameover → best stays 12, and the display alternates 005/012 every 4 cycles.
- MAX_SCORE=999, 1005 points → score=999, hex all 0010000, with no wrap to 000.
- point and gameover on the same cycle at score=7 → final score=8, best=8, phase=10. Assert reset mid-SHOW_BEST → dashes, best=0 on the next cycle.
